// File: rtl/avalon_arb_pkg.sv
// Shared types and helpers for the Avalon-ST packet arbiter.
// Optional per-input packet counters are enabled with AVALON_ARB_STATS_EN.
package avalon_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int CNT_W = 16;

    function automatic int idx_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST packet stream bundle with source (master) and sink (slave) views.
// Carries data/valid/sop/eop/empty forward and rdy backward.
interface avalon_st_if #(
    parameter int DATA_WIDTH_IN_BYTES = 16
);
    localparam int EMPTY_W = $clog2(DATA_WIDTH_IN_BYTES);

    logic [DATA_WIDTH_IN_BYTES*8-1:0] data;
    logic                             valid;
    logic                             sop;
    logic                             eop;
    logic [EMPTY_W-1:0]               empty;
    logic                             rdy;

    modport master (
        output data,
        output valid,
        output sop,
        output eop,
        output empty,
        input  rdy
    );

    modport slave (
        input  data,
        input  valid,
        input  sop,
        input  eop,
        input  empty,
        output rdy
    );

endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first requester strictly after ptr,
// found by scanning a doubled request vector so the wrap needs no special case.
module rr_priority_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] pick_o,
    output logic          pick_valid_o
);

    logic [2*N-1:0] dbl;
    logic [IW:0]    cand;
    logic [IW:0]    pos;

    always_comb begin
        dbl  = {req_i, req_i};
        cand = '0;
        pos  = '0;
        // Scan from farthest to nearest so the nearest hit wins.
        for (int j = N; j >= 1; j--) begin
            cand = {1'b0, ptr_i} + (IW+1)'(j);
            if (dbl[cand]) begin
                pos = cand;
            end
        end
        if (pos >= (IW+1)'(N)) begin
            pick_o = IW'(pos - (IW+1)'(N));
        end else begin
            pick_o = IW'(pos);
        end
        pick_valid_o = |req_i;
    end

endmodule

// File: rtl/avalon_packet_arbiter.sv
// Packet-granular round-robin merge of NUM_INPUTS Avalon-ST streams.
// Define AVALON_ARB_STATS_EN to add saturating per-input packet counters.
module avalon_packet_arbiter
    import avalon_arb_pkg::*;
#(
    parameter int DATA_WIDTH_IN_BYTES = 16,
    parameter int NUM_INPUTS          = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    avalon_st_if.slave                         in_msgs [NUM_INPUTS],
    avalon_st_if.master                        out_msg,
    output logic                               grant_valid,
    output logic [idx_width(NUM_INPUTS)-1:0]   grant_idx,
`ifdef AVALON_ARB_STATS_EN
    output logic [NUM_INPUTS-1:0][CNT_W-1:0]   pkt_count,
`endif
    output logic                               orphan_drop
);

    localparam int IW = idx_width(NUM_INPUTS);
    localparam int DW = DATA_WIDTH_IN_BYTES * 8;
    localparam int EW = $clog2(DATA_WIDTH_IN_BYTES);

    logic [DW-1:0]         data_w  [NUM_INPUTS];
    logic [EW-1:0]         empty_w [NUM_INPUTS];
    logic [NUM_INPUTS-1:0] valid_w;
    logic [NUM_INPUTS-1:0] sop_w;
    logic [NUM_INPUTS-1:0] eop_w;
    logic [NUM_INPUTS-1:0] rdy_w;
    logic [NUM_INPUTS-1:0] cand_w;
    logic [NUM_INPUTS-1:0] orphan_w;
    logic                  out_rdy;

    arb_state_t  state_q, state_d;
    logic [IW-1:0] grant_idx_q, grant_idx_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic          orphan_q, orphan_d;
    logic [IW-1:0] pick;
    logic          pick_valid;
    logic          locked;
    logic          eop_xfer;

    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_in
        assign data_w[g]      = in_msgs[g].data;
        assign empty_w[g]     = in_msgs[g].empty;
        assign valid_w[g]     = in_msgs[g].valid;
        assign sop_w[g]       = in_msgs[g].sop;
        assign eop_w[g]       = in_msgs[g].eop;
        assign in_msgs[g].rdy = rdy_w[g];
    end

    assign out_rdy  = out_msg.rdy;
    assign locked   = (state_q == LOCKED);
    assign cand_w   = valid_w & sop_w;
    assign orphan_w = valid_w & ~sop_w;
    assign eop_xfer = locked & valid_w[grant_idx_q]
                    & eop_w[grant_idx_q] & out_rdy;

    rr_priority_picker #(
        .N  (NUM_INPUTS),
        .IW (IW)
    ) u_picker (
        .req_i        (cand_w),
        .ptr_i        (rr_ptr_q),
        .pick_o       (pick),
        .pick_valid_o (pick_valid)
    );

    // Zero-latency pass-through of the granted stream; muted while idle.
    assign out_msg.data  = data_w[grant_idx_q];
    assign out_msg.empty = empty_w[grant_idx_q];
    assign out_msg.sop   = sop_w[grant_idx_q];
    assign out_msg.eop   = eop_w[grant_idx_q];
    assign out_msg.valid = locked & valid_w[grant_idx_q];

    always_comb begin
        rdy_w = '0;
        if (locked) begin
            rdy_w[grant_idx_q] = out_rdy;
        end else begin
            rdy_w = orphan_w;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        rr_ptr_d    = rr_ptr_q;
        orphan_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                orphan_d = |orphan_w;
                if (pick_valid) begin
                    grant_idx_d = pick;
                    rr_ptr_d    = pick;
                    state_d     = LOCKED;
                end
            end
            LOCKED: begin
                if (eop_xfer) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_idx_q <= '0;
            rr_ptr_q    <= IW'(NUM_INPUTS - 1);
            orphan_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            orphan_q    <= orphan_d;
        end
    end

    assign grant_valid = locked;
    assign grant_idx   = grant_idx_q;
    assign orphan_drop = orphan_q;

`ifdef AVALON_ARB_STATS_EN
    logic [NUM_INPUTS-1:0][CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (eop_xfer && (cnt_q[grant_idx_q] != '1)) begin
            cnt_q[grant_idx_q] <= cnt_q[grant_idx_q] + CNT_W'(1);
        end
    end

    assign pkt_count = cnt_q;
`endif

endmodule
